// File: rtl/xbar_ch_reorder_buf.sv
// Per-channel read-return reorder buffer. Hands out in-order 3-bit tags for
// read requests and accepts out-of-order returns from four banks. Data goes
// back to the channel strictly in tag order over a valid/ready handshake.
module xbar_ch_reorder_buf #(
    parameter logic [1:0] CH_ID = 2'd0
) (
    input  logic         clk_i,
    input  logic         rst_i,

    input  logic         alloc_valid_i,
    output logic         alloc_ready_o,
    output logic [2:0]   alloc_rob_num_o,

    input  logic         bank0_sc_xbar_valid_i,
    output logic         bank0_sc_xbar_allowIn_o,
    input  logic [1:0]   bank0_sc_xbar_ch_id_i,
    input  logic [2:0]   bank0_sc_xbar_rob_num_i,
    input  logic [127:0] bank0_sc_xbar_data_i,

    input  logic         bank1_sc_xbar_valid_i,
    output logic         bank1_sc_xbar_allowIn_o,
    input  logic [1:0]   bank1_sc_xbar_ch_id_i,
    input  logic [2:0]   bank1_sc_xbar_rob_num_i,
    input  logic [127:0] bank1_sc_xbar_data_i,

    input  logic         bank2_sc_xbar_valid_i,
    output logic         bank2_sc_xbar_allowIn_o,
    input  logic [1:0]   bank2_sc_xbar_ch_id_i,
    input  logic [2:0]   bank2_sc_xbar_rob_num_i,
    input  logic [127:0] bank2_sc_xbar_data_i,

    input  logic         bank3_sc_xbar_valid_i,
    output logic         bank3_sc_xbar_allowIn_o,
    input  logic [1:0]   bank3_sc_xbar_ch_id_i,
    input  logic [2:0]   bank3_sc_xbar_rob_num_i,
    input  logic [127:0] bank3_sc_xbar_data_i,

    output logic         ch_rtn_data_valid_o,
    input  logic         ch_rtn_data_ready_i,
    output logic [127:0] ch_rtn_data_o,

    output logic         rob_err_o
);

    localparam int unsigned Depth = 8;
    localparam int unsigned NumBanks = 4;

    logic [Depth-1:0] alloc_q, alloc_d;
    logic [Depth-1:0] done_q, done_d;
    logic [127:0]     data_q [Depth];
    logic [2:0]       head_q, head_d;
    logic [2:0]       tail_q, tail_d;
    logic [3:0]       count_q, count_d;
    logic             err_q, err_d;

    logic [NumBanks-1:0] bank_valid;
    logic [1:0]          bank_ch [NumBanks];
    logic [2:0]          bank_tag [NumBanks];
    logic [127:0]        bank_data [NumBanks];

    logic [NumBanks-1:0] bank_hit;
    logic [NumBanks-1:0] bank_dup;
    logic [NumBanks-1:0] bank_we;
    logic                fill_err;
    logic                alloc_fire;
    logic                alloc_err;
    logic                pop;

    assign bank_valid = {bank3_sc_xbar_valid_i, bank2_sc_xbar_valid_i,
                         bank1_sc_xbar_valid_i, bank0_sc_xbar_valid_i};
    assign bank_ch[0]   = bank0_sc_xbar_ch_id_i;
    assign bank_ch[1]   = bank1_sc_xbar_ch_id_i;
    assign bank_ch[2]   = bank2_sc_xbar_ch_id_i;
    assign bank_ch[3]   = bank3_sc_xbar_ch_id_i;
    assign bank_tag[0]  = bank0_sc_xbar_rob_num_i;
    assign bank_tag[1]  = bank1_sc_xbar_rob_num_i;
    assign bank_tag[2]  = bank2_sc_xbar_rob_num_i;
    assign bank_tag[3]  = bank3_sc_xbar_rob_num_i;
    assign bank_data[0] = bank0_sc_xbar_data_i;
    assign bank_data[1] = bank1_sc_xbar_data_i;
    assign bank_data[2] = bank2_sc_xbar_data_i;
    assign bank_data[3] = bank3_sc_xbar_data_i;

    // Entries are reserved at allocation, so returns are never back-pressured.
    assign bank0_sc_xbar_allowIn_o = 1'b1;
    assign bank1_sc_xbar_allowIn_o = 1'b1;
    assign bank2_sc_xbar_allowIn_o = 1'b1;
    assign bank3_sc_xbar_allowIn_o = 1'b1;

    assign alloc_ready_o       = (count_q != 4'd8);
    assign alloc_rob_num_o     = tail_q;
    assign alloc_fire          = alloc_valid_i & alloc_ready_o;
    assign alloc_err           = alloc_valid_i & ~alloc_ready_o;
    assign ch_rtn_data_valid_o = alloc_q[head_q] & done_q[head_q];
    assign ch_rtn_data_o       = ch_rtn_data_valid_o ? data_q[head_q] : '0;
    assign pop                 = ch_rtn_data_valid_o & ch_rtn_data_ready_i;
    assign rob_err_o           = err_q;

    // Decode bank returns: lowest bank wins a same-tag collision; a winner
    // only writes if its entry is allocated and still waiting for data.
    always_comb begin
        bank_hit = '0;
        bank_dup = '0;
        bank_we  = '0;
        fill_err = 1'b0;
        for (int b = 0; b < NumBanks; b++) begin
            bank_hit[b] = bank_valid[b] & (bank_ch[b] == CH_ID);
        end
        for (int b = 1; b < NumBanks; b++) begin
            for (int c = 0; c < b; c++) begin
                if (bank_hit[b] && bank_hit[c] && (bank_tag[b] == bank_tag[c])) begin
                    bank_dup[b] = 1'b1;
                end
            end
        end
        for (int b = 0; b < NumBanks; b++) begin
            bank_we[b] = bank_hit[b] & ~bank_dup[b] & alloc_q[bank_tag[b]] &
                         ~done_q[bank_tag[b]];
            if (bank_dup[b] || (bank_hit[b] && !bank_we[b])) begin
                fill_err = 1'b1;
            end
        end
    end

    // Next-state for entry flags, pointers, occupancy and the sticky error.
    always_comb begin
        alloc_d = alloc_q;
        done_d  = done_q;
        for (int b = 0; b < NumBanks; b++) begin
            if (bank_we[b]) begin
                done_d[bank_tag[b]] = 1'b1;
            end
        end
        if (pop) begin
            alloc_d[head_q] = 1'b0;
            done_d[head_q]  = 1'b0;
        end
        // Tail never equals an allocated head here, so this cannot clash with pop.
        if (alloc_fire) begin
            alloc_d[tail_q] = 1'b1;
            done_d[tail_q]  = 1'b0;
        end
        head_d  = pop ? head_q + 3'd1 : head_q;
        tail_d  = alloc_fire ? tail_q + 3'd1 : tail_q;
        count_d = count_q + {3'd0, alloc_fire} - {3'd0, pop};
        err_d   = err_q | alloc_err | fill_err;
    end

    // Control state register; reset discards all entries immediately.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            alloc_q <= '0;
            done_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            alloc_q <= alloc_d;
            done_q  <= done_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // Payload storage; unreset because the output is masked until done is set.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < NumBanks; b++) begin
            if (bank_we[b]) begin
                data_q[bank_tag[b]] <= bank_data[b];
            end
        end
    end

endmodule

// File: tb/tb_xbar_ch_reorder_buf.sv
// Self-checking bench for xbar_ch_reorder_buf: a vector table for ordinary
// traffic plus directed sequences for full/wrap, backpressure, errors and reset.
module tb_xbar_ch_reorder_buf;

    logic         clk;
    logic         rst;
    logic         alloc_valid;
    logic         alloc_ready;
    logic [2:0]   alloc_rob;
    logic         bv [4];
    logic [1:0]   bch [4];
    logic [2:0]   btag [4];
    logic [127:0] bdat [4];
    logic [3:0]   allow_in;
    logic         rtn_valid;
    logic         rdy;
    logic [127:0] rtn_data;
    logic         rob_err;

    int checks = 0;
    int errors = 0;
    logic [23:0]  salt;
    logic [127:0] sb [$];

    typedef struct {
        logic       alloc;
        logic       fv;
        int         bank;
        logic [1:0] ch;
        logic [2:0] tag;
        logic       ev;
        logic [2:0] erob;
        logic       erdy;
        logic       eerr;
    } vec_t;

    vec_t tbl [20];

    xbar_ch_reorder_buf #(.CH_ID(2'd1)) dut (
        .clk_i                   (clk),
        .rst_i                   (rst),
        .alloc_valid_i           (alloc_valid),
        .alloc_ready_o           (alloc_ready),
        .alloc_rob_num_o         (alloc_rob),
        .bank0_sc_xbar_valid_i   (bv[0]),
        .bank0_sc_xbar_allowIn_o (allow_in[0]),
        .bank0_sc_xbar_ch_id_i   (bch[0]),
        .bank0_sc_xbar_rob_num_i (btag[0]),
        .bank0_sc_xbar_data_i    (bdat[0]),
        .bank1_sc_xbar_valid_i   (bv[1]),
        .bank1_sc_xbar_allowIn_o (allow_in[1]),
        .bank1_sc_xbar_ch_id_i   (bch[1]),
        .bank1_sc_xbar_rob_num_i (btag[1]),
        .bank1_sc_xbar_data_i    (bdat[1]),
        .bank2_sc_xbar_valid_i   (bv[2]),
        .bank2_sc_xbar_allowIn_o (allow_in[2]),
        .bank2_sc_xbar_ch_id_i   (bch[2]),
        .bank2_sc_xbar_rob_num_i (btag[2]),
        .bank2_sc_xbar_data_i    (bdat[2]),
        .bank3_sc_xbar_valid_i   (bv[3]),
        .bank3_sc_xbar_allowIn_o (allow_in[3]),
        .bank3_sc_xbar_ch_id_i   (bch[3]),
        .bank3_sc_xbar_rob_num_i (btag[3]),
        .bank3_sc_xbar_data_i    (bdat[3]),
        .ch_rtn_data_valid_o     (rtn_valid),
        .ch_rtn_data_ready_i     (rdy),
        .ch_rtn_data_o           (rtn_data),
        .rob_err_o               (rob_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] dat(input logic [2:0] t);
        return {4{salt, 5'd0, t}};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Advance one clock and drop single-cycle pulses; leaves time at edge + 1.
    task automatic cyc();
        @(posedge clk);
        #1;
        alloc_valid = 1'b0;
        for (int b = 0; b < 4; b++) bv[b] = 1'b0;
    endtask

    task automatic fill(input int b, input logic [1:0] ch, input logic [2:0] t,
                        input logic [127:0] d);
        bv[b]   = 1'b1;
        bch[b]  = ch;
        btag[b] = t;
        bdat[b] = d;
    endtask

    task automatic do_alloc(input logic [2:0] t);
        alloc_valid = 1'b1;
        check("alloc_tag", alloc_rob, t);
        check("alloc_ready", alloc_ready, 1'b1);
        sb.push_back(dat(t));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
    endtask

    // Scoreboard monitor: each completed handshake must match the oldest request.
    always @(negedge clk) begin
        if (!rst && rtn_valid && rdy) begin
            if (sb.size() == 0) begin
                check("unexpected_delivery", 1'b1, 1'b0);
            end else begin
                check("deliver_data", rtn_data, sb.pop_front());
            end
        end
    end

    initial begin
        rst = 1'b1;
        alloc_valid = 1'b0;
        rdy = 1'b0;
        salt = 24'h0;
        for (int b = 0; b < 4; b++) begin
            bv[b] = 1'b0; bch[b] = 2'd0; btag[b] = 3'd0; bdat[b] = '0;
        end
        //          alloc fv bank ch tag  ev erob erdy eerr
        tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 1, 0};
        tbl[1]  = '{0, 1, 2, 1, 0, 0, 1, 1, 0};
        tbl[2]  = '{0, 0, 0, 0, 0, 1, 1, 1, 0};
        tbl[3]  = '{0, 0, 0, 0, 0, 0, 1, 1, 0};
        tbl[4]  = '{1, 0, 0, 0, 0, 0, 1, 1, 0};
        tbl[5]  = '{1, 0, 0, 0, 0, 0, 2, 1, 0};
        tbl[6]  = '{1, 0, 0, 0, 0, 0, 3, 1, 0};
        tbl[7]  = '{0, 1, 1, 1, 3, 0, 4, 1, 0};
        tbl[8]  = '{0, 1, 3, 1, 2, 0, 4, 1, 0};
        tbl[9]  = '{0, 1, 0, 1, 1, 0, 4, 1, 0};
        tbl[10] = '{0, 0, 0, 0, 0, 1, 4, 1, 0};
        tbl[11] = '{0, 0, 0, 0, 0, 1, 4, 1, 0};
        tbl[12] = '{0, 0, 0, 0, 0, 1, 4, 1, 0};
        tbl[13] = '{0, 0, 0, 0, 0, 0, 4, 1, 0};
        tbl[14] = '{1, 0, 0, 0, 0, 0, 4, 1, 0};
        tbl[15] = '{0, 1, 0, 2, 4, 0, 5, 1, 0};
        tbl[16] = '{0, 0, 0, 0, 0, 0, 5, 1, 0};
        tbl[17] = '{0, 1, 1, 1, 4, 0, 5, 1, 0};
        tbl[18] = '{0, 0, 0, 0, 0, 1, 5, 1, 0};
        tbl[19] = '{0, 0, 0, 0, 0, 0, 5, 1, 0};

        @(posedge clk);
        #1;
        do_reset();

        // Reset state
        check("rst_alloc_ready", alloc_ready, 1'b1);
        check("rst_rob_num", alloc_rob, 3'd0);
        check("rst_valid", rtn_valid, 1'b0);
        check("rst_data", rtn_data, '0);
        check("rst_err", rob_err, 1'b0);
        check("rst_allow_in", allow_in, 4'hF);

        // Table: in-order, out-of-order and foreign-channel returns
        salt = 24'h1A5A5A;
        rdy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            alloc_valid = tbl[i].alloc;
            if (tbl[i].fv) fill(tbl[i].bank, tbl[i].ch, tbl[i].tag, dat(tbl[i].tag));
            check($sformatf("row%0d_valid", i), rtn_valid, tbl[i].ev);
            check($sformatf("row%0d_rob", i), alloc_rob, tbl[i].erob);
            check($sformatf("row%0d_ready", i), alloc_ready, tbl[i].erdy);
            check($sformatf("row%0d_err", i), rob_err, tbl[i].eerr);
            if (tbl[i].alloc && tbl[i].erdy) sb.push_back(dat(tbl[i].erob));
            cyc();
        end

        // Full and wrap
        do_reset();
        salt = 24'h200000;
        rdy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            do_alloc(3'(i));
            cyc();
        end
        check("full_ready", alloc_ready, 1'b0);
        check("full_rob", alloc_rob, 3'd0);
        fill(0, 2'd1, 3'd0, dat(3'd0));
        cyc();
        check("full_head_valid", rtn_valid, 1'b1);
        rdy = 1'b1;
        cyc();
        rdy = 1'b0;
        check("after_pop_ready", alloc_ready, 1'b1);
        do_alloc(3'd0);
        cyc();
        check("refull_ready", alloc_ready, 1'b0);
        check("refull_rob", alloc_rob, 3'd1);
        check("pre_ovf_err", rob_err, 1'b0);
        alloc_valid = 1'b1;
        cyc();
        check("ovf_err", rob_err, 1'b1);
        check("ovf_rob_held", alloc_rob, 3'd1);
        do_reset();
        check("reset_clears_err", rob_err, 1'b0);

        // Backpressure and simultaneous alloc, pop and four fills
        salt = 24'h3C3C00;
        rdy = 1'b0;
        for (int i = 0; i < 7; i++) begin
            do_alloc(3'(i));
            cyc();
        end
        for (int b = 0; b < 3; b++) fill(b, 2'd1, 3'(b), dat(3'(b)));
        cyc();
        for (int k = 0; k < 5; k++) begin
            check("bp_valid", rtn_valid, 1'b1);
            check("bp_data", rtn_data, dat(3'd0));
            cyc();
        end
        rdy = 1'b1;
        do_alloc(3'd7);
        for (int b = 0; b < 4; b++) fill(b, 2'd1, 3'(b + 3), dat(3'(b + 3)));
        cyc();
        rdy = 1'b0;
        check("simul_valid", rtn_valid, 1'b1);
        check("simul_data", rtn_data, dat(3'd1));
        do_alloc(3'd0);
        cyc();
        check("simul_count_full", alloc_ready, 1'b0);
        rdy = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            check("drain_valid", rtn_valid, 1'b1);
            cyc();
        end
        check("drain_stall", rtn_valid, 1'b0);
        fill(3, 2'd1, 3'd7, dat(3'd7));
        fill(2, 2'd1, 3'd0, dat(3'd0));
        cyc();
        check("tail7_valid", rtn_valid, 1'b1);
        cyc();
        check("tail0_valid", rtn_valid, 1'b1);
        cyc();
        check("empty_valid", rtn_valid, 1'b0);
        check("empty_ready", alloc_ready, 1'b1);
        check("simul_err", rob_err, 1'b0);

        // Protocol errors must not disturb delivery order
        do_reset();
        salt = 24'h5E5E00;
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            do_alloc(3'(i));
            cyc();
        end
        check("pre_err", rob_err, 1'b0);
        fill(1, 2'd1, 3'd5, 128'h5);
        cyc();
        check("nonalloc_err", rob_err, 1'b1);
        fill(0, 2'd1, 3'd1, dat(3'd1));
        fill(2, 2'd1, 3'd1, ~dat(3'd1));
        cyc();
        fill(3, 2'd1, 3'd1, 128'hDEAD);
        cyc();
        check("dup_valid", rtn_valid, 1'b0);
        fill(2, 2'd1, 3'd0, dat(3'd0));
        fill(1, 2'd1, 3'd2, dat(3'd2));
        cyc();
        rdy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check("err_order_valid", rtn_valid, 1'b1);
            cyc();
        end
        check("err_drained", rtn_valid, 1'b0);
        check("err_sticky", rob_err, 1'b1);

        // Asynchronous reset with four entries pending
        salt = 24'h6A6A00;
        rdy = 1'b0;
        for (int i = 3; i < 7; i++) begin
            do_alloc(3'(i));
            cyc();
        end
        fill(0, 2'd1, 3'd3, dat(3'd3));
        fill(1, 2'd1, 3'd4, dat(3'd4));
        cyc();
        check("pend_valid", rtn_valid, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("async_ready", alloc_ready, 1'b1);
        check("async_rob", alloc_rob, 3'd0);
        check("async_valid", rtn_valid, 1'b0);
        check("async_data", rtn_data, '0);
        check("async_err", rob_err, 1'b0);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        do_alloc(3'd0);
        cyc();
        fill(0, 2'd1, 3'd4, dat(3'd4));
        cyc();
        check("stale_rtn_err", rob_err, 1'b1);
        check("stale_rtn_valid", rtn_valid, 1'b0);
        fill(3, 2'd1, 3'd0, dat(3'd0));
        cyc();
        rdy = 1'b1;
        check("post_rst_valid", rtn_valid, 1'b1);
        cyc();
        check("post_rst_empty", rtn_valid, 1'b0);
        check("sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/xbar_ch_reorder_buf.md
# xbar_ch_reorder_buf

Per-channel read-return reorder buffer in the cross-bar, directly downstream of the four bank return ports (`bankN_sc_xbar_*`) and upstream of the mcash channel return port. It allocates an in-order 3-bit ROB tag for every read request that leaves the channel, and accepts out-of-order 128-bit returns from any of the four banks, filtered by channel id. It delivers data to the channel strictly in request order over a valid/ready handshake. One instance exists per mcash channel; `alloc_ready_o` gates the channel's request allowIn.

## Interface
Parameters:
- CH_ID, default 2'd0: channel this instance serves; only bank returns with matching `ch_id` are captured.

Ports:
- clk_i  in  1  clock; single clock domain.
- rst_i  in  1  reset; asynchronous, active-high.
- alloc_valid_i  in  1  read request kickoff for this channel (valid & allowIn & read op).
- alloc_ready_o  out  1  ROB has a free entry; ANDed into the channel req allowIn by the parent.
- alloc_rob_num_o  out  3  tag for the request kicked off this cycle (= tail pointer); forwarded with the request.
- bank{0..3}_sc_xbar_valid_i  in  1  bank N return valid.
- bank{0..3}_sc_xbar_allowIn_o  out  1  constant 1; entries are pre-reserved, so returns never stall.
- bank{0..3}_sc_xbar_ch_id_i  in  2  return's channel id.
- bank{0..3}_sc_xbar_rob_num_i  in  3  return's ROB tag.
- bank{0..3}_sc_xbar_data_i  in  128  return data.
- ch_rtn_data_valid_o  out  1  head entry filled.
- ch_rtn_data_ready_i  in  1  channel accepts return.
- ch_rtn_data_o  out  128  head data; 0 when valid is low.
- rob_err_o  out  1  sticky protocol error; cleared only by reset.

## Operation
- Storage: 8 entries, each with `alloc`, `done`, data[127:0]. Pointers `head`[2:0] and `tail`[2:0], plus `count`[3:0] (0..8). Pointers wrap 7->0.
- Allocate: on `alloc_valid_i & alloc_ready_o`, set entry[tail] alloc=1, done=0; tail+1; count+1. `alloc_ready_o = (count != 8)`. The parent must not assert `alloc_valid_i` while `alloc_ready_o`=0; doing so is ignored and sets `rob_err_o`.
- Fill: a bank return hits this instance when `valid & ch_id==CH_ID`. On a hit, entry[rob_num] gets done=1 and its data is written.
  - Up to 4 hits per cycle to distinct tags are all accepted.
  - Hit on an entry with alloc=0 or done=1: ignored, `rob_err_o` set.
  - Two or more hits to the same tag in one cycle: the lowest bank index wins, and `rob_err_o` is set.
- Deliver: `ch_rtn_data_valid_o = entry[head].alloc & entry[head].done`. On valid & ready, clear entry[head], head+1, count-1. Data stays stable while valid and not ready.
- Simultaneous alloc and pop: count unchanged, and both pointers advance. When full (count=8), alloc is blocked that cycle even if a pop occurs; there is no same-cycle bypass.
- A fill to tag==tail in the same cycle as its allocation counts as a non-allocated hit (error, ignored).

## Timing
- Reset values: all alloc/done=0, head=tail=0, count=0, rob_err_o=0. Outputs: alloc_ready_o=1, alloc_rob_num_o=0, ch_rtn_data_valid_o=0, ch_rtn_data_o=0, bank allowIn_o=1.
- Reset asserted mid-operation discards all entries immediately (async). Outstanding bank returns after reset deassertion hit non-allocated entries and are flagged as errors.
- `alloc_rob_num_o` and `alloc_ready_o` are registered-state outputs, valid in the same cycle as the kickoff.
- Fill-to-deliver latency: a return captured at edge N shows valid in cycle N+1 if it is the head entry. A fill cannot be delivered in the cycle it is captured.
- Throughput: one delivery per cycle when the head is ready; one allocation per cycle.

## Test plan
- In-order single read: alloc (tag 0); bank2 returns ch=CH_ID, rob=0, data=0xA5.. -> valid next cycle with 0xA5..; after pop, count=0 and alloc_ready=1.
- Out-of-order: alloc tags 0,1,2; banks return 2, 0, 1 on separate cycles -> valid only after tag 0 arrives; data delivered in order 0,1,2 on consecutive cycles with ready held 1.
- Full/wrap: 8 allocs -> alloc_ready=0 and tag sequence 0..7. Pop one -> alloc_ready=1 next cycle and the next tag issued is 0.
- Backpressure plus simultaneous events: ready=0 holds valid/data stable for 5 cycles. Four banks fill tags 3..6 in one cycle while alloc and pop also occur -> all captured and count correct.
- Errors: return to a non-allocated tag, duplicate return, and same-tag two-bank collision -> rob_err_o=1 sticky and delivery order unaffected. Return with a different ch_id -> ignored, no error.
- Async reset with 4 entries pending -> all outputs return to reset values immediately; subsequent alloc issues tag 0.
